// File: rtl/column_stream_scheduler.sv
// Sweeps the scan indices of one rotation step, fetches the column groups of every
// unmasked index from a pipelined generator and streams them out over valid/ready.
module column_stream_scheduler #(
    parameter int ROTATIONAL_RES   = 256,
    parameter int NUM_ROWS         = 64,
    parameter int SCAN_RATE        = 32,
    parameter int NUM_GROUPS       = 2,
    parameter int RGB_RES          = 9,
    parameter int NUM_MODES        = 4,
    parameter int SRC_LATENCY      = 1,
    parameter int RESTART_ON_THETA = 1,
    localparam int NUM_COLS = NUM_GROUPS * SCAN_RATE,
    localparam int THETA_W  = $clog2(ROTATIONAL_RES),
    localparam int MODE_W   = $clog2(NUM_MODES),
    localparam int IDX_W    = $clog2(SCAN_RATE),
    localparam int COL_W    = $clog2(NUM_COLS)
) (
    input  logic                                               clk_in,
    input  logic                                               rst_n_in,
    input  logic                                               enable,
    input  logic [THETA_W-1:0]                                 dtheta,
    input  logic [MODE_W-1:0]                                  mode,
    input  logic [SCAN_RATE-1:0]                               col_mask,
    output logic                                               src_req,
    output logic [NUM_GROUPS-1:0][COL_W-1:0]                   src_index,
    output logic [THETA_W-1:0]                                 src_theta,
    output logic [MODE_W-1:0]                                  src_mode,
    input  logic [NUM_GROUPS-1:0][NUM_ROWS-1:0][RGB_RES-1:0]   src_cols,
    output logic [NUM_GROUPS-1:0][NUM_ROWS-1:0][RGB_RES-1:0]   columns,
    output logic [IDX_W-1:0]                                   col_num,
    output logic                                               out_valid,
    input  logic                                               out_ready,
    output logic                                               sweep_done,
    output logic                                               sweep_abort,
    output logic                                               busy
);

    localparam int CNT_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        ISSUE,
        WAIT,
        HOLD
    } state_t;

    state_t                                             state_q, state_d;
    logic [IDX_W-1:0]                                   idx_q, idx_d;
    logic [CNT_W-1:0]                                   cnt_q, cnt_d;
    logic [SCAN_RATE-1:0]                               mask_q, mask_d;
    logic [THETA_W-1:0]                                 theta_q, theta_d;
    logic [MODE_W-1:0]                                  mode_q, mode_d;
    logic [NUM_GROUPS-1:0][NUM_ROWS-1:0][RGB_RES-1:0]   columns_q, columns_d;
    logic [IDX_W-1:0]                                   col_num_q, col_num_d;
    logic                                               done_q, done_d;
    logic                                               abort_q, abort_d;

    logic   theta_chg;
    logic   last_idx;
    state_t end_state;

    assign theta_chg = (RESTART_ON_THETA != 0) && (dtheta != theta_q);
    assign last_idx  = (idx_q == IDX_W'(SCAN_RATE - 1));
    assign end_state = enable ? LATCH : IDLE;

    // NOTE: every signal written here gets its default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        theta_d   = theta_q;
        mode_d    = mode_q;
        columns_d = columns_q;
        col_num_d = col_num_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        src_req   = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) state_d = LATCH;
            end
            LATCH: begin
                theta_d = dtheta;
                mode_d  = mode;
                mask_d  = col_mask;
                idx_d   = '0;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (theta_chg) begin
                    abort_d = 1'b1;
                    state_d = LATCH;
                end else if (!mask_q[idx_q]) begin
                    if (last_idx) begin
                        done_d  = 1'b1;
                        state_d = end_state;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (mode_q == '0) begin
                    // Blank mode never touches the generator.
                    columns_d = '0;
                    col_num_d = idx_q;
                    state_d   = HOLD;
                end else begin
                    src_req = 1'b1;
                    cnt_d   = CNT_W'(SRC_LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (theta_chg) begin
                    abort_d = 1'b1;
                    state_d = LATCH;
                end else if (cnt_q == CNT_W'(1)) begin
                    columns_d = src_cols;
                    col_num_d = idx_q;
                    state_d   = HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    // A pending restart wins over advancing, including on the last index.
                    if (theta_chg) begin
                        abort_d = 1'b1;
                        state_d = LATCH;
                    end else if (last_idx) begin
                        done_d  = 1'b1;
                        state_d = end_state;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    // NOTE: the column data register is reset too, because its contents are a visible output that must read 0 in reset.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            mask_q    <= '0;
            theta_q   <= '0;
            mode_q    <= '0;
            columns_q <= '0;
            col_num_q <= '0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            theta_q   <= theta_d;
            mode_q    <= mode_d;
            columns_q <= columns_d;
            col_num_q <= col_num_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
        end
    end

    // Index is forced to 0 when idle so every output reads 0 out of reset.
    always_comb begin
        for (int g = 0; g < NUM_GROUPS; g++) begin
            src_index[g] = (state_q != IDLE) ? (COL_W'(g * SCAN_RATE) + COL_W'(idx_q)) : '0;
        end
    end

    assign src_theta   = theta_q;
    assign src_mode    = mode_q;
    assign columns     = columns_q;
    assign col_num     = col_num_q;
    assign sweep_done  = done_q;
    assign sweep_abort = abort_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_column_stream_scheduler.sv
// Directed bench for column_stream_scheduler: a registered one-cycle generator model,
// a negedge monitor logging beats/requests/pulses, and one task per scenario.
module tb_column_stream_scheduler;

    localparam int SR = 32;
    localparam int NG = 2;
    localparam int NR = 64;
    localparam int RB = 9;

    typedef logic [NG-1:0][5:0]           idx_t;
    typedef logic [NG-1:0][NR-1:0][RB-1:0] cols_t;

    logic         clk_in = 1'b0;
    logic         rst_n_in;
    logic         enable;
    logic [7:0]   dtheta;
    logic [1:0]   mode;
    logic [SR-1:0] col_mask;
    logic         src_req;
    idx_t         src_index;
    logic [7:0]   src_theta;
    logic [1:0]   src_mode;
    cols_t        src_cols;
    cols_t        columns;
    logic [4:0]   col_num;
    logic         out_valid;
    logic         out_ready;
    logic         sweep_done;
    logic         sweep_abort;
    logic         busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    column_stream_scheduler dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .enable      (enable),
        .dtheta      (dtheta),
        .mode        (mode),
        .col_mask    (col_mask),
        .src_req     (src_req),
        .src_index   (src_index),
        .src_theta   (src_theta),
        .src_mode    (src_mode),
        .src_cols    (src_cols),
        .columns     (columns),
        .col_num     (col_num),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sweep_done  (sweep_done),
        .sweep_abort (sweep_abort),
        .busy        (busy)
    );

    initial forever #5 clk_in = ~clk_in;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic cols_t gen_pattern(input idx_t ix, input logic [7:0] th, input logic [1:0] md);
        cols_t p;
        for (int g = 0; g < NG; g++)
            for (int r = 0; r < NR; r++)
                p[g][r] = RB'(int'(ix[g]) * 11 + r * 3 + int'(th) + int'(md) * 5);
        return p;
    endfunction

    function automatic idx_t exp_index(input int i);
        idx_t e;
        e[0] = 6'(i);
        e[1] = 6'(i + SR);
        return e;
    endfunction

    // Generator model with one cycle of latency; junk data on non-request cycles.
    always @(posedge clk_in)
        src_cols <= src_req ? gen_pattern(src_index, src_theta, src_mode) : '1;

    always @(posedge clk_in) cyc <= cyc + 1;

    int         hs_cyc[$];
    logic [4:0] hs_col[$];
    cols_t      hs_data[$];
    int         req_cyc[$];
    idx_t       req_idx[$];
    logic [7:0] req_theta[$];
    int         done_cyc[$];
    int         abort_cyc[$];
    int         coincide = 0;

    always @(negedge clk_in) begin
        if (rst_n_in) begin
            if (out_valid && out_ready) begin
                hs_cyc.push_back(cyc);
                hs_col.push_back(col_num);
                hs_data.push_back(columns);
            end
            if (src_req) begin
                req_cyc.push_back(cyc);
                req_idx.push_back(src_index);
                req_theta.push_back(src_theta);
            end
            if (sweep_done)  done_cyc.push_back(cyc);
            if (sweep_abort) abort_cyc.push_back(cyc);
            if (sweep_done && sweep_abort) coincide++;
        end
    end

    task automatic clear_mon();
        hs_cyc.delete(); hs_col.delete(); hs_data.delete();
        req_cyc.delete(); req_idx.delete(); req_theta.delete();
        done_cyc.delete(); abort_cyc.delete();
        coincide = 0;
    endtask

    task automatic start_sweep(input logic [7:0] th, input logic [1:0] md,
                               input logic [SR-1:0] mk, output int start);
        @(posedge clk_in); #1;
        dtheta = th; mode = md; col_mask = mk; enable = 1'b1;
        start = cyc;
        @(posedge clk_in); #1;
        enable = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk_in);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(posedge clk_in);
        #1;
    endtask

    task automatic find_req(input int target, output bit ok, output int c);
        ok = 1'b0;
        c  = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_in);
            if (src_req && src_index[0] == 6'(target)) begin
                ok = 1'b1;
                c  = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0; enable = 1'b0; out_ready = 1'b1;
        dtheta = 8'd0; mode = 2'd0; col_mask = '0;
        #12;
        total++;
        if ({src_req, out_valid, busy, sweep_done, sweep_abort} !== 5'b0 ||
            src_index !== '0 || src_theta !== '0 || src_mode !== '0 || col_num !== '0) begin
            bad++;
            $display("FAIL reset_outputs: req=%b valid=%b busy=%b done=%b abort=%b idx=%h theta=%h mode=%h col=%h, want all 0",
                     src_req, out_valid, busy, sweep_done, sweep_abort, src_index, src_theta, src_mode, col_num);
        end
        total++;
        if (columns !== '0) begin
            bad++;
            $display("FAIL reset_columns: row0=%h, want 0", columns[0][0]);
        end
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        repeat (3) @(negedge clk_in);
        total++;
        if (busy !== 1'b0 || src_req !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%b req=%b, want 0 0", busy, src_req);
        end
    endtask

    task automatic test_full_sweep();
        int start; bit ok; cols_t exp;
        clear_mon();
        out_ready = 1'b1;
        start_sweep(8'd5, 2'd1, '1, start);
        wait_idle(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL full_timeout: busy stuck, want idle"); end
        total++;
        if (hs_col.size() != 32) begin
            bad++; $display("FAIL full_beats: got %0d beats, want 32", hs_col.size());
        end
        for (int i = 0; i < hs_col.size() && i < 32; i++) begin
            exp = gen_pattern(exp_index(i), 8'd5, 2'd1);
            total++;
            if (hs_col[i] !== 5'(i) || hs_data[i] !== exp) begin
                bad++;
                $display("FAIL full_beat%0d: col=%0d row0=%h/%h, want col=%0d row0=%h/%h",
                         i, hs_col[i], hs_data[i][0][0], hs_data[i][1][0], i, exp[0][0], exp[1][0]);
            end
        end
        total++;
        if (req_idx.size() != 32) begin
            bad++; $display("FAIL full_reqs: got %0d requests, want 32", req_idx.size());
        end
        for (int i = 0; i < req_idx.size() && i < 32; i++) begin
            total++;
            if (req_idx[i] !== exp_index(i) || req_theta[i] !== 8'd5) begin
                bad++;
                $display("FAIL full_src_index%0d: got %h theta=%0d, want %h theta=5",
                         i, req_idx[i], req_theta[i], exp_index(i));
            end
        end
        if (hs_cyc.size() == 32) begin
            total++;
            if (hs_cyc[0] != start + 4) begin
                bad++; $display("FAIL full_first_latency: beat at %0d, want %0d", hs_cyc[0], start + 4);
            end
            for (int i = 1; i < 32; i++) begin
                total++;
                if (hs_cyc[i] - hs_cyc[i-1] != 3) begin
                    bad++; $display("FAIL full_spacing%0d: got %0d cycles, want 3", i, hs_cyc[i] - hs_cyc[i-1]);
                end
            end
            total++;
            if (done_cyc.size() != 1 || done_cyc[0] != hs_cyc[31] + 1) begin
                bad++;
                $display("FAIL full_done: count=%0d first=%0d, want count=1 at %0d",
                         done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1, hs_cyc[31] + 1);
            end
        end
        total++;
        if (abort_cyc.size() != 0) begin
            bad++; $display("FAIL full_no_abort: got %0d aborts, want 0", abort_cyc.size());
        end
    endtask

    task automatic test_scanline_skip();
        int start; bit ok;
        clear_mon();
        start_sweep(8'd9, 2'd2, 32'h0000_0005, start);
        wait_idle(ok);
        total++;
        if (!ok || hs_col.size() != 2 || req_idx.size() != 2) begin
            bad++;
            $display("FAIL skip_counts: idle=%b beats=%0d reqs=%0d, want 1 2 2", ok, hs_col.size(), req_idx.size());
        end else begin
            total++;
            if (hs_col[0] !== 5'd0 || hs_col[1] !== 5'd2 ||
                hs_data[1] !== gen_pattern(exp_index(2), 8'd9, 2'd2)) begin
                bad++; $display("FAIL skip_cols: got %0d,%0d, want 0,2 with matching data", hs_col[0], hs_col[1]);
            end
            total++;
            if (req_idx[0] !== exp_index(0) || req_idx[1] !== exp_index(2)) begin
                bad++; $display("FAIL skip_reqs: got %h,%h, want %h,%h", req_idx[0], req_idx[1], exp_index(0), exp_index(2));
            end
            total++;
            if (hs_cyc[0] != start + 4 || hs_cyc[1] != hs_cyc[0] + 4) begin
                bad++; $display("FAIL skip_timing: beats at %0d,%0d, want %0d,%0d", hs_cyc[0], hs_cyc[1], start + 4, start + 8);
            end
            total++;
            if (done_cyc.size() != 1 || done_cyc[0] != hs_cyc[1] + 30) begin
                bad++;
                $display("FAIL skip_done: count=%0d first=%0d, want count=1 at %0d",
                         done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1, hs_cyc[1] + 30);
            end
        end
    endtask

    task automatic test_empty_mask();
        int start; bit ok;
        clear_mon();
        start_sweep(8'd1, 2'd1, '0, start);
        wait_idle(ok);
        total++;
        if (!ok || hs_col.size() != 0 || req_idx.size() != 0 || done_cyc.size() != 1) begin
            bad++;
            $display("FAIL empty_counts: idle=%b beats=%0d reqs=%0d dones=%0d, want 1 0 0 1",
                     ok, hs_col.size(), req_idx.size(), done_cyc.size());
        end else begin
            total++;
            if (done_cyc[0] != start + 34) begin
                bad++; $display("FAIL empty_done_time: got %0d, want %0d", done_cyc[0], start + 34);
            end
        end
    endtask

    task automatic test_backpressure();
        int start; int c; bit ok; cols_t exp;
        clear_mon();
        out_ready = 1'b1;
        exp = gen_pattern(exp_index(3), 8'd3, 2'd3);
        start_sweep(8'd3, 2'd3, '1, start);
        find_req(3, ok, c);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_find_req3: no request for index 3"); end
        @(posedge clk_in); #1;
        out_ready = 1'b0;
        @(posedge clk_in); #1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_in);
            total++;
            if (out_valid !== 1'b1 || src_req !== 1'b0 || col_num !== 5'd3 || columns !== exp) begin
                bad++;
                $display("FAIL bp_hold%0d: valid=%b req=%b col=%0d row0=%h, want 1 0 3 %h",
                         k, out_valid, src_req, col_num, columns[0][0], exp[0][0]);
            end
        end
        @(posedge clk_in); #1;
        out_ready = 1'b1;
        wait_idle(ok);
        total++;
        if (!ok || hs_col.size() != 32 || done_cyc.size() != 1) begin
            bad++;
            $display("FAIL bp_counts: idle=%b beats=%0d dones=%0d, want 1 32 1", ok, hs_col.size(), done_cyc.size());
        end else begin
            total++;
            if (hs_col[3] !== 5'd3 || hs_col[4] !== 5'd4 || hs_cyc[3] != c + 12 || hs_cyc[4] != c + 15) begin
                bad++;
                $display("FAIL bp_release: cols=%0d,%0d at %0d,%0d, want 3,4 at %0d,%0d",
                         hs_col[3], hs_col[4], hs_cyc[3], hs_cyc[4], c + 12, c + 15);
            end
        end
    endtask

    task automatic test_theta_restart();
        int start; int c; bit ok;
        clear_mon();
        out_ready = 1'b1;
        start_sweep(8'd5, 2'd1, '1, start);
        find_req(7, ok, c);
        total++;
        if (!ok) begin bad++; $display("FAIL theta_find_req7: no request for index 7"); end
        @(posedge clk_in); #1;
        dtheta = 8'd6;
        wait_idle(ok);
        total++;
        if (!ok || abort_cyc.size() != 1 || hs_col.size() != 39 || req_idx.size() != 40) begin
            bad++;
            $display("FAIL theta_counts: idle=%b aborts=%0d beats=%0d reqs=%0d, want 1 1 39 40",
                     ok, abort_cyc.size(), hs_col.size(), req_idx.size());
        end else begin
            total++;
            if (abort_cyc[0] != c + 2) begin
                bad++; $display("FAIL theta_abort_time: got %0d, want %0d", abort_cyc[0], c + 2);
            end
            total++;
            if (hs_col[6] !== 5'd6 || hs_col[7] !== 5'd0 ||
                hs_data[7] !== gen_pattern(exp_index(0), 8'd6, 2'd1)) begin
                bad++; $display("FAIL theta_next_beat: cols=%0d,%0d, want 6,0 with theta 6 data", hs_col[6], hs_col[7]);
            end
            total++;
            if (req_theta[8] !== 8'd6 || req_idx[8] !== exp_index(0) || req_cyc[8] != c + 3) begin
                bad++;
                $display("FAIL theta_relatch: theta=%0d idx=%h at %0d, want 6 %h at %0d",
                         req_theta[8], req_idx[8], req_cyc[8], exp_index(0), c + 3);
            end
        end
        total++;
        if (done_cyc.size() != 1 || coincide != 0) begin
            bad++; $display("FAIL theta_pulses: dones=%0d overlaps=%0d, want 1 0", done_cyc.size(), coincide);
        end
    endtask

    task automatic test_blank_mode();
        int start; bit ok;
        clear_mon();
        out_ready = 1'b1;
        start_sweep(8'h20, 2'd0, '1, start);
        wait_idle(ok);
        total++;
        if (!ok || hs_col.size() != 32 || req_idx.size() != 0 || done_cyc.size() != 1) begin
            bad++;
            $display("FAIL blank_counts: idle=%b beats=%0d reqs=%0d dones=%0d, want 1 32 0 1",
                     ok, hs_col.size(), req_idx.size(), done_cyc.size());
        end else begin
            for (int i = 0; i < 32; i++) begin
                total++;
                if (hs_col[i] !== 5'(i) || hs_data[i] !== '0) begin
                    bad++;
                    $display("FAIL blank_beat%0d: col=%0d row0=%h, want col=%0d zeros", i, hs_col[i], hs_data[i][0][0], i);
                end
            end
            total++;
            if (hs_cyc[0] != start + 3 || hs_cyc[31] - hs_cyc[0] != 62) begin
                bad++;
                $display("FAIL blank_timing: first=%0d span=%0d, want %0d 62", hs_cyc[0], hs_cyc[31] - hs_cyc[0], start + 3);
            end
        end
    endtask

    task automatic test_reset_mid();
        int start; bit ok;
        clear_mon();
        out_ready = 1'b0;
        start_sweep(8'd1, 2'd1, '1, start);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_in);
            if (out_valid) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) begin bad++; $display("FAIL rst_reach_hold: out_valid never rose"); end
        @(posedge clk_in); #3;
        rst_n_in = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || col_num !== '0 || src_theta !== '0 || columns !== '0) begin
            bad++;
            $display("FAIL rst_async: valid=%b busy=%b col=%0d theta=%0d, want all 0", out_valid, busy, col_num, src_theta);
        end
        @(posedge clk_in); #1;
        rst_n_in  = 1'b1;
        out_ready = 1'b1;
        clear_mon();
        repeat (5) @(negedge clk_in);
        total++;
        if (busy !== 1'b0 || hs_col.size() != 0 || req_idx.size() != 0) begin
            bad++;
            $display("FAIL rst_stays_idle: busy=%b beats=%0d reqs=%0d, want 0 0 0", busy, hs_col.size(), req_idx.size());
        end
        start_sweep(8'd2, 2'd1, 32'h0000_0001, start);
        wait_idle(ok);
        total++;
        if (!ok || hs_col.size() != 1 || done_cyc.size() != 1) begin
            bad++;
            $display("FAIL rst_restart: idle=%b beats=%0d dones=%0d, want 1 1 1", ok, hs_col.size(), done_cyc.size());
        end else begin
            total++;
            if (hs_col[0] !== 5'd0 || hs_data[0] !== gen_pattern(exp_index(0), 8'd2, 2'd1)) begin
                bad++; $display("FAIL rst_restart_beat: col=%0d row0=%h, want col=0 fresh data", hs_col[0], hs_data[0][0][0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_sweep();
        test_scanline_skip();
        test_empty_mask();
        test_backpressure();
        test_theta_restart();
        test_blank_mode();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/column_stream_scheduler.md
# column_stream_scheduler

Parametrised successor to the rotational frame manager. Per rotation step, it sweeps the SCAN_RATE scan indices once and skips indices masked off by the scanline mask. For each active index it requests NUM_GROUPS columns from an external, pipelined column generator, and streams the result to the HUB75 driver over a valid/ready handshake. It sits between `col_calc`/the frame generators and the HUB75 driver, and fixes the prior single-cycle, unpipelined data path.

## Interface
- ROTATIONAL_RES, 256: angular steps per revolution.
- NUM_ROWS, 64: pixels per column.
- SCAN_RATE, 32: scan indices per sweep; NUM_COLS = NUM_GROUPS*SCAN_RATE.
- NUM_GROUPS, 2: columns delivered per beat (panel halves).
- RGB_RES, 9: bits per pixel.
- NUM_MODES, 4: display modes; mode 0 is blank.
- SRC_LATENCY, 1: generator latency in cycles, 1..7.
- RESTART_ON_THETA, 1: 1 restarts the sweep when dtheta changes; 0 finishes the sweep first.

Ports:
- clk_in, in, 1: sole clock.
- rst_n_in, in, 1: reset, asynchronous, active-low.
- enable, in, 1: permit new sweeps.
- dtheta, in, $clog2(ROTATIONAL_RES): current angle.
- mode, in, $clog2(NUM_MODES): display mode.
- col_mask, in, SCAN_RATE: bit i=1 means index i is emitted.
- src_req, out, 1: one-cycle generator request.
- src_index, out, [NUM_GROUPS][$clog2(NUM_COLS)]: entry g = g*SCAN_RATE+idx.
- src_theta, out, $clog2(ROTATIONAL_RES): latched sweep angle.
- src_mode, out, $clog2(NUM_MODES): latched sweep mode.
- src_cols, in, [NUM_GROUPS][NUM_ROWS][RGB_RES]: generator data.
- columns, out, [NUM_GROUPS][NUM_ROWS][RGB_RES]: beat data.
- col_num, out, $clog2(SCAN_RATE): scan index of the beat.
- out_valid, out, 1; out_ready, in, 1: HUB75 handshake.
- sweep_done, out, 1: pulse after the last index is accepted or skipped.
- sweep_abort, out, 1: pulse when a sweep is restarted.
- busy, out, 1: state != IDLE.

## Operation
States:
- **IDLE**
  - Enters LATCH when enable=1.
- **LATCH**, one cycle
  - Captures dtheta, mode and col_mask into src_theta, src_mode and mask_q; sets idx=0; goes to ISSUE.
- **ISSUE**
  - If mask_q[idx]=0: skip, idx++, one cycle per skip.
  - If mask_q[idx]=1 and src_mode=0: load columns=0, col_num=idx, go to HOLD; no request is made.
  - If mask_q[idx]=1 and src_mode!=0: pulse src_req, load the wait counter with SRC_LATENCY, go to WAIT.
- **WAIT**
  - Counts down; on the last count captures src_cols into columns, sets col_num=idx, goes to HOLD.
- **HOLD**
  - out_valid=1. On out_valid&&out_ready, idx++ and leave.
- **End of sweep**
  - When idx would pass SCAN_RATE-1, by accept or skip: pulse sweep_done.
  - Next state is LATCH if enable=1, else IDLE.

Rules:
- src_index, src_theta and src_mode are held stable from src_req until capture.
- The generator must not see them change mid-flight.
- Theta change, RESTART_ON_THETA=1:
  - dtheta!=src_theta while in ISSUE or WAIT: drop any in-flight request, pulse sweep_abort, go to LATCH.
  - In HOLD: the beat completes on its handshake, then the abort and LATCH happen instead of advancing.
- Theta change, RESTART_ON_THETA=0: dtheta is ignored until the sweep ends.
- A mode or col_mask change mid-sweep takes effect only at the next LATCH.
- enable deasserted mid-sweep: the current sweep finishes; no new sweep starts.
- All-zero mask: SCAN_RATE skip cycles, then sweep_done, with no beats emitted.
- idx wraps SCAN_RATE-1 → 0 only through LATCH.
- Index arithmetic is unsigned; g*SCAN_RATE+idx must stay below NUM_COLS.

## Timing
- Reset values: all outputs 0, state IDLE.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0; any in-flight capture is discarded.
- LATCH is at cycle t.
  - First active index 0: src_req at t+1, capture at t+1+SRC_LATENCY, out_valid at t+2+SRC_LATENCY.
  - Each masked-off index ahead of it adds 1 cycle.
  - Mode 0: out_valid at t+2.
- out_valid is never withdrawn without a handshake, except on reset.
- columns and col_num are stable while out_valid=1.
- Back-to-back beats: minimum 2+SRC_LATENCY cycles per beat, with out_ready tied high.
- sweep_done and sweep_abort are single-cycle registered pulses and never coincide.

## Test plan
- **Full sweep:** SRC_LATENCY=1, mask all ones, out_ready=1, mode=1.
  - Expect 32 beats, col_num 0..31.
  - src_index = {idx, idx+32}.
  - One sweep_done, exactly one cycle after the idx=31 accept.
- **Scanline skip:** mask=32'h0000_0005.
  - Expect exactly 2 beats, col_num 0 then 2, and no src_req for other indices.
  - sweep_done 30 skip-cycles after the second accept.
- **Backpressure:** hold out_ready=0 for 10 cycles during beat 3.
  - Expect out_valid held, columns/col_num stable, and no src_req in that window.
- **Theta restart:** change dtheta 5→6 while in WAIT at idx=7.
  - Expect sweep_abort pulse, no beat for idx 7, LATCH, src_theta=6, next col_num 0.
- **Blank mode:** mode=0, mask all ones.
  - Expect 32 beats of zeros and src_req never asserted.
- **Reset:** assert rst_n_in=0 asynchronously in HOLD.
  - Expect out_valid and busy to go 0 without a clock edge.
  - After release, idle until enable.
